ext_div_unit: RTL and testbench
===============================

Name: ext_div_unit

Overview:
Sequential RV32M divide/remainder extension unit for the CPU external-execution port.
- Sits beside the multiplier on the same ext* handshake (start/a/b/func3 in; r/done out).
- The CPU stalls on extStart until extDone.
- Radix-2 restoring divider, one quotient bit per cycle; signed operands are handled by magnitude conversion and a final sign fix.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  operation request; sampled only in IDLE.
a  input  WIDTH  dividend (rs1).
b  input  WIDTH  divisor (rs2).
func3  input  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
r  output  WIDTH  result (quotient or remainder); registered, held until next accepted start.
done  output  1  one-cycle completion pulse; r valid while done=1.
busy  output  1  high from accept through the done cycle.

Behaviour:
- Reset (async, any state): state=IDLE; r=0; done=0; busy=0; counter, remainder and quotient registers=0.
- States:
  - IDLE -> CALC on an edge with start=1 and func3[2]=1.
  - CALC -> DONE after the WIDTH-th iteration.
  - DONE -> IDLE unconditionally.
- Accept, at edge E0:
  - Latch op (signed = ~func3[0], want_rem = func3[1]).
  - Latch |a| and |b| (magnitudes only when signed).
  - Latch neg_q = signed & (a[31]^b[31]) & (b!=0) and neg_r = signed & a[31].
  - Latch flags div0 = (b==0) and ovf = signed & (a==0x80000000) & (b==0xFFFFFFFF).
  - Keep original a for the div0 remainder.
  - Set counter=0, busy=1.
- CALC, edges E1..E32, one iteration each:
  - rem' = {rem[30:0], dvd[31]}; dvd shifts left.
  - If rem' >= divisor: rem = rem' - divisor and shift in quotient bit 1; else shift in 0.
  - Use a 33-bit subtract for the compare.
  - Counter wraps at WIDTH-1; at E32 the final result is registered into r and state -> DONE.
- Result selection, registered at E32:
  - div0: quotient = all ones; remainder = original a.
  - ovf: quotient = 0x80000000; remainder = 0.
  - Otherwise: quotient negated if neg_q; remainder negated if neg_r.
  - r = want_rem ? remainder : quotient.
- Latency: done=1 in the cycle between E32 and E33, identical for all operands including div0/ovf (no early exit). busy falls at E33.
- start while busy (CALC or DONE): ignored, not queued; the CPU must re-assert start after done.
- start with func3[2]=0 (MUL family): ignored; no done, r unchanged.
- Inputs a/b/func3 may change after E0 without effect.
- r holds its value after DONE until the next accepted start's E32 (not cleared at accept).
- Reset asserted mid-CALC: returns to IDLE immediately; no done pulse; r=0.

Decomposition:
- Shared package:
  - func3 constants F3_DIV=3'b100, F3_DIVU=3'b101, F3_REM=3'b110, F3_REMU=3'b111.
  - State encoding IDLE/CALC/DONE.
  - Constant INT_MIN=32'h8000_0000.
- Sub-module div_step: combinational one-bit restoring step (rem, dvd, divisor in -> rem, dvd, qbit out). Natural and reusable for a future radix-4 variant.
- FSM, counter, sign handling and result mux stay in ext_div_unit.

Test Plan:
- DIVU a=100, b=7, start at E0 -> done exactly at E32 cycle, r=14; REMU same operands -> r=2; busy high E0..E33.
- DIV a=-7 (0xFFFFFFF9), b=2 -> r=0xFFFFFFFD (-3); REM same -> r=0xFFFFFFFF (-1); REM a=7, b=-2 -> r=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> r=0x80000000; REM same -> r=0; latency still 32.
- Divide by zero: DIVU a=5, b=0 -> r=0xFFFFFFFF; DIV a=-5, b=0 -> r=0xFFFFFFFF; REM a=-5, b=0 -> r=0xFFFFFFFB.
- Start pulsed again at E10 with different operands -> ignored, first result delivered at E32, single done pulse; start with func3=3'b000 in IDLE -> no done within 40 cycles, r unchanged.
- Assert rst asynchronously mid-cycle at E15 -> done=0, busy=0, r=0 immediately; after release a fresh DIVU 9/3 -> r=3 at 32-cycle latency.

Source files
------------

// File: rtl/ext_div_unit_pkg.sv
// rtl/ext_div_unit_pkg.sv - shared constants and state encoding for the divide unit
package ext_div_unit_pkg;

    localparam logic [2:0]  F3_DIV  = 3'b100;
    localparam logic [2:0]  F3_DIVU = 3'b101;
    localparam logic [2:0]  F3_REM  = 3'b110;
    localparam logic [2:0]  F3_REMU = 3'b111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ext_div_unit_if.sv
// rtl/ext_div_unit_if.sv - ext* execution-port handshake between CPU and divide unit
interface ext_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       func3;
    logic [WIDTH-1:0] r;
    logic             done;
    logic             busy;

    modport master (
        output start, a, b, func3,
        input  r, done, busy
    );

    modport slave (
        input  start, a, b, func3,
        output r, done, busy
    );
endinterface

// File: rtl/ext_div_unit_div_step.sv
// rtl/ext_div_unit_div_step.sv - one combinational radix-2 restoring divide step
module ext_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next,
    output logic             qbit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor on entry keeps shifted below 2*divisor, so diff's top bit is an exact borrow.
    assign shifted  = {rem, dvd[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = ~diff[WIDTH];
    assign rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_next = {dvd[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/ext_div_unit.sv
// rtl/ext_div_unit.sv - sequential RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle
module ext_div_unit
    import ext_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ext_div_unit_if.slave s
);
    localparam int                CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, dvd_q, quo_q, dsr_q, a_orig_q, r_q;
    logic             want_rem_q, neg_q_q, neg_r_q, div0_q, ovf_q;

    logic             accept, last, sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem, step_dvd;
    logic             step_q;
    logic [WIDTH-1:0] quo_fin, quo_sel, rem_sel;

    assign accept = (state == IDLE) && s.start && s.func3[2];
    assign last   = (state == CALC) && (cnt == LAST);
    assign sgn    = ~s.func3[0];
    assign a_mag  = (sgn && s.a[WIDTH-1]) ? -s.a : s.a;
    assign b_mag  = (sgn && s.b[WIDTH-1]) ? -s.b : s.b;

    ext_div_unit_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd      (dvd_q),
        .divisor  (dsr_q),
        .rem_next (step_rem),
        .dvd_next (step_dvd),
        .qbit     (step_q)
    );

    assign quo_fin = {quo_q[WIDTH-2:0], step_q};

    // Special cases override the iterated result; the iteration still runs full length.
    always_comb begin
        quo_sel = neg_q_q ? -quo_fin : quo_fin;
        rem_sel = neg_r_q ? -step_rem : step_rem;
        if (div0_q) begin
            quo_sel = '1;
            rem_sel = a_orig_q;
        end else if (ovf_q) begin
            quo_sel = MIN_NEG;
            rem_sel = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            a_orig_q   <= '0;
            r_q        <= '0;
            want_rem_q <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            rem_q      <= '0;
            dvd_q      <= a_mag;
            quo_q      <= '0;
            dsr_q      <= b_mag;
            a_orig_q   <= s.a;
            want_rem_q <= s.func3[1];
            neg_q_q    <= sgn && (s.a[WIDTH-1] ^ s.b[WIDTH-1]) && (s.b != '0);
            neg_r_q    <= sgn && s.a[WIDTH-1];
            div0_q     <= (s.b == '0);
            ovf_q      <= sgn && (s.a == MIN_NEG) && (s.b == '1);
        end else if (state == CALC) begin
            rem_q <= step_rem;
            dvd_q <= step_dvd;
            quo_q <= quo_fin;
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
                r_q <= want_rem_q ? rem_sel : quo_sel;
            end
        end
    end

    assign s.r    = r_q;
    assign s.done = (state == DONE);
    assign s.busy = (state != IDLE);

endmodule

// File: tb/tb_ext_div_unit.sv
// tb/tb_ext_div_unit.sv - directed self-checking bench for ext_div_unit
module tb_ext_div_unit;
    import ext_div_unit_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    ext_div_unit_if #(.WIDTH(32)) bus ();

    ext_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one op and checks busy/done timing across E0..E33 plus the result.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp);
        logic early_done;
        logic busy_drop;
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk({tag, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
        early_done = 1'b0;
        busy_drop  = 1'b0;
        repeat (31) begin
            @(posedge clk);
            #1;
            if (bus.done) early_done = 1'b1;
            if (!bus.busy) busy_drop = 1'b1;
        end
        chk({tag, "_no_early_done"}, {31'd0, early_done}, 32'd0);
        chk({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_e32"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_r"}, bus.r, exp);
        @(posedge clk);
        #1;
        chk({tag, "_done_e33"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_busy_e33"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_r_held"}, bus.r, exp);
    endtask

    initial begin
        logic saw_done;
        logic saw_busy;
        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.func3 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_r", bus.r, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2);
        run_op("divu_big", F3_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
        run_op("remu_big", F3_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("rem_7_m2", F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("div_ovf", F3_DIV, INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", F3_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_div0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("div_div0", F3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_div0", F3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);

        // MUL-family start must be ignored while r holds the last result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'b000;
        bus.a     = 32'd40;
        bus.b     = 32'd2;
        saw_done  = 1'b0;
        saw_busy  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) saw_done = 1'b1;
            if (bus.busy) saw_busy = 1'b1;
        end
        chk("mul_no_done", {31'd0, saw_done}, 32'd0);
        chk("mul_no_busy", {31'd0, saw_busy}, 32'd0);
        chk("mul_r_unchanged", bus.r, 32'hFFFF_FFFB);

        // A second start at E10 is dropped; only the first op completes.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = F3_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = F3_DIVU;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        saw_done  = 1'b0;
        repeat (21) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("restart_no_early_done", {31'd0, saw_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("restart_done_e32", {31'd0, bus.done}, 32'd1);
        chk("restart_r_first_op", bus.r, 32'd14);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("restart_single_done", {31'd0, saw_done}, 32'd0);

        // Asynchronous reset in the middle of the E15 cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = F3_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_r", bus.r, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
